// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the fetch front end.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    localparam logic [31:0] NOP_INST   = 32'h00000033;
    localparam logic [2:0]  FUNC3_WORD = 3'b010;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Synchronous FIFO of fetch entries; flush beats push and pop.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  fetch_entry_t               push_entry,
    input  logic                       pop,
    input  logic                       flush,
    output fetch_entry_t               head_entry,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;
    fetch_entry_t     mem_q [DEPTH];

    always_comb begin
        do_pop   = pop && (count_q != '0);
        // A full queue still accepts a push when the head leaves in the same cycle.
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!flush && do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign head_entry = mem_q[rd_ptr_q];
    assign count      = count_q;

endmodule
`default_nettype wire

// File: rtl/fetch_prefetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_prefetch_queue
// Description : Fetch front end with prefetch queue and unified-port arbiter.
//               Optional same-cycle head bypass: FETCH_BYPASS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int          ADDR_W   = 8,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic [ADDR_W-1:0]          mem_addr,
    output logic                       mem_rd,
    output logic                       mem_wr,
    output logic [2:0]                 mem_func3,
    output logic [31:0]                mem_wdata,
    input  logic [31:0]                mem_rdata,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [2:0]                 d_func3,
    input  logic [ADDR_W-1:0]          d_addr,
    input  logic [31:0]                d_wdata,
    output logic [31:0]                d_rdata,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    input  logic                       halt,
    output logic                       if_valid,
    output logic [31:0]                if_inst,
    output logic [31:0]                if_pc,
    input  logic                       if_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic             started_q, started_d;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head_entry, push_entry;
    logic             q_valid, room, fetch_en, bypass, q_push, q_pop;

    always_comb begin
        q_valid  = (count != '0);
        q_pop    = q_valid && if_ready;
        room     = (count != CNT_W'(DEPTH)) || q_pop;
        // started_q keeps the port idle while reset is asserted.
        fetch_en = started_q && !d_req && !redirect && !halt && room;
`ifdef FETCH_BYPASS_EN
        bypass   = fetch_en && !q_valid;
`else
        bypass   = 1'b0;
`endif
        q_push          = fetch_en && !(bypass && if_ready);
        push_entry.pc   = fetch_pc_q;
        push_entry.inst = mem_rdata;

        started_d  = 1'b1;
        fetch_pc_d = fetch_pc_q;
        if (redirect)      fetch_pc_d = {redirect_pc[31:2], 2'b00};
        else if (fetch_en) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    always_comb begin
        mem_addr  = '0;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_func3 = 3'b000;
        if (d_req) begin
            mem_addr  = d_addr;
            mem_rd    = !d_we;
            mem_wr    = d_we;
            mem_func3 = d_func3;
        end else if (fetch_en) begin
            mem_addr  = fetch_pc_q[ADDR_W-1:0];
            mem_rd    = 1'b1;
            mem_func3 = FUNC3_WORD;
        end
    end

    always_comb begin
        if_valid = q_valid || bypass;
        if_inst  = NOP_INST;
        if_pc    = '0;
        if (q_valid) begin
            if_inst = head_entry.inst;
            if_pc   = head_entry.pc;
        end else if (bypass) begin
            if_inst = mem_rdata;
            if_pc   = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            started_q  <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            started_q  <= started_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .push_entry (push_entry),
        .pop        (q_pop),
        .flush      (redirect),
        .head_entry (head_entry),
        .count      (count)
    );

    assign q_count   = count;
    assign d_rdata   = mem_rdata;
    assign mem_wdata = d_wdata;

endmodule
`default_nettype wire

// File: doc/fetch_prefetch_queue.md
# fetch_prefetch_queue

Instruction fetch front end for the pipelined RV32 core, with a prefetch FIFO and an arbiter for the single unified memory port. It sits between the PC logic and decode. Each cycle it grants the one memory port to the MEM-stage data access if one is requested, and otherwise to instruction fetch. Prefetched instructions are buffered so that data accesses no longer stall the front end, and the queue is flushed on branch or jump redirect.

## Interface
Parameters:
- `ADDR_W`, default 8: byte-address width of the unified memory.
- `DEPTH`, default 4: prefetch entries; must be a power of two and ≥ 2.
- `RESET_PC`, default 32'h0: first fetch address after reset.

Ports:
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `mem_addr`  out  `ADDR_W`: memory byte address.
- `mem_rd`  out  1: memory read enable.
- `mem_wr`  out  1: memory write enable; the write commits at the rising edge.
- `mem_func3`  out  3: access size/sign; 3'b010 for fetch.
- `mem_wdata`  out  32: store data.
- `mem_rdata`  in  32: combinational read data.
- `d_req`  in  1: MEM-stage data access request.
- `d_we`  in  1: 1 = store, 0 = load.
- `d_func3`  in  3: load/store func3.
- `d_addr`  in  `ADDR_W`: data address.
- `d_wdata`  in  32: store data.
- `d_rdata`  out  32: load data, valid in the same cycle as `d_req`.
- `redirect`  in  1: taken branch or jump; flush the queue and refetch.
- `redirect_pc`  in  32: new fetch PC.
- `halt`  in  1: ecall/ebreak decoded; stop issuing fetches.
- `if_valid`  out  1: head entry is valid.
- `if_inst`  out  32: head instruction.
- `if_pc`  out  32: head PC.
- `if_ready`  in  1: decode consumes the head this cycle.
- `q_count`  out  clog2(`DEPTH`+1): occupancy.

## Operation
Port grant, evaluated each cycle:
- If `d_req` = 1, the port is granted to data: `mem_addr` = `d_addr`, `mem_func3` = `d_func3`, `mem_rd` = !`d_we`, `mem_wr` = `d_we`. `d_rdata` = `mem_rdata`.
- Otherwise a fetch is issued when all of these hold: `redirect` = 0, `halt` = 0, and either occupancy < `DEPTH` or a pop occurs this cycle.
- A fetch drives `mem_addr` = `fetch_pc[ADDR_W-1:0]`, `mem_rd` = 1, `mem_func3` = 3'b010.
- With no grant: `mem_rd` = `mem_wr` = 0 and `mem_addr` = 0.

Fetch and queue:
- A fetch pushes {`fetch_pc`, `mem_rdata`} into the queue and sets `fetch_pc` += 4.
- The 32-bit PC wraps naturally. The memory address is the truncation of `fetch_pc` to `ADDR_W` bits, so it wraps mod 2^`ADDR_W`.
- A pop occurs when `if_valid` && `if_ready`. A push and a pop may occur in the same cycle, including when the queue is full.
- `if_valid` = (occupancy ≠ 0).
- When the queue is empty, `if_inst` = 32'h00000033 (NOP) and `if_pc` = 0.

Redirect:
- `redirect` has priority over push and pop.
- Occupancy becomes 0 and `fetch_pc` becomes {`redirect_pc[31:2]`, 2'b00}.
- No fetch is issued in the redirect cycle.
- A data access in the same cycle is still serviced.

`halt` blocks new fetches only. Queued entries still drain, and `redirect` is still honoured.

## Timing
- Reset values: `fetch_pc` = `RESET_PC`, occupancy 0, `if_valid` 0, `if_inst` 32'h00000033, `if_pc` 0, `q_count` 0, `mem_rd` = `mem_wr` = 0.
- Reset asserted mid-operation discards all queued entries immediately.
- Fetch-to-head latency is 1 cycle: an instruction fetched in cycle t is visible at the head in cycle t+1.
- Redirect in cycle t: fetch in t+1; `if_valid` in t+2 (t+1 with the bypass below).
- A stream of back-to-back `d_req` starves fetch indefinitely. The queue only drains during that time.
- `d_rdata` is combinational from `mem_rdata`, with zero added latency.

## Configuration
Macro: `FETCH_BYPASS_EN`.
- When defined: if the queue is empty and a fetch is granted, `if_valid` = 1, `if_inst` = `mem_rdata` and `if_pc` = `fetch_pc` in the same cycle. If `if_ready` is also high that cycle, the entry is consumed and not enqueued.
- When not defined: instructions reach decode only through the queue, with 1-cycle latency.

## Structure
- Package `fetch_pkg` holds:
  - `NOP_INST` = 32'h00000033
  - `FUNC3_WORD` = 3'b010
  - `fetch_entry_t` = {pc[31:0], inst[31:0]}
- Sub-module `fetch_fifo`: a synchronous FIFO of `fetch_entry_t` with parameter `DEPTH`. It has push, pop, flush and count, and read and write pointers that wrap at `DEPTH`. Flush has priority over push and pop.

## Test plan
- Reset release, memory holding distinct words at 0x00–0x1C, `if_ready` = 0 → four fetches at 0x00, 0x04, 0x08, 0x0C; `q_count` reaches 4; no further `mem_rd`; head `if_pc` = 0.
- Queue full, `if_ready` = 1 on a continuous basis → one push and one pop per cycle; `q_count` stays 4; the `if_pc` sequence is 0, 4, 8, … with no gaps.
- `d_req` store to 0x40 (`d_we` = 1, `d_wdata` = 0xDEADBEEF) during a fetch stream → the fetch is skipped that cycle and `mem_wr` = 1 at 0x40. A following load from 0x40 returns `d_rdata` = 0xDEADBEEF in its request cycle.
- `redirect` = 1 with `redirect_pc` = 0x22, queue holding 3 entries, `if_ready` high → `q_count` = 0 next cycle; the next fetch is at 0x20; the first `if_pc` after the flush is 0x20.
- `ADDR_W` = 8 with `fetch_pc` = 0xFC → the next fetch has `mem_addr` 0x00 and `if_pc` 0x100; with `halt` = 1, no fetches occur and the queue drains to empty.
- With `FETCH_BYPASS_EN` defined and the queue empty after a redirect → `if_valid` = 1 in the cycle after the redirect, with `if_inst` = `mem_rdata`.
